// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD adder/subtractor,
// one digit per clock, LSD first, valid/ready both sides.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic          rsub;
  logic          c;
  logic [IW-1:0] idx;
  logic [3:0]    bd;
  logic [3:0]    dig;
  logic [4:0]    raw;
  logic          carry;
  logic          bad;

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (a[4*i +: 4] > 4'd9)
                | (b[4*i +: 4] > 4'd9);
    end
  end

  // operands shift right, so digit i always sits at [3:0]
  always_comb begin
    bd    = rsub ? 4'd9 - rb[3:0] : rb[3:0];
    raw   = {1'b0, ra[3:0]} + {1'b0, bd}
          + {4'd0, c};
    carry = raw > 5'd9;
    dig   = carry ? raw[3:0] + 4'd6 : raw[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rsub      <= 1'b0;
      c         <= 1'b0;
      idx       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ra    <= a;
            rb    <= b;
            c     <= cin;
            rsub  <= sub;
            err   <= bad;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= dig;
          ra  <= ra >> 4;
          rb  <= rb >> 4;
          c   <= carry;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= carry;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb_bcd_serial_addsub: table, hand and random checks
// on DIGITS = 1, 4 and 16 instances driven in parallel.
module tb_bcd_serial_addsub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;

  logic        rdy1, rdy4, rdy16;
  logic        ov1, ov4, ov16;
  logic [3:0]  s1;
  logic [15:0] s4;
  logic [63:0] s16;
  logic        co1, co4, co16;
  logic        er1, er4, er16;

  int tests = 0;
  int failed = 0;
  int dg[3];

  logic [63:0] rs[3];
  logic        rc[3];
  logic        re[3];
  int          rl[3];
  bit          rg[3];

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(rdy1), .a(a[3:0]), .b(b[3:0]),
    .cin(cin), .sub(sub), .out_valid(ov1),
    .out_ready(out_ready), .sum(s1), .cout(co1),
    .err(er1));

  bcd_serial_addsub #(.DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(rdy4), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov4),
    .out_ready(out_ready), .sum(s4), .cout(co4),
    .err(er4));

  bcd_serial_addsub #(.DIGITS(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(rdy16), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov16),
    .out_ready(out_ready), .sum(s16), .cout(co16),
    .err(er16));

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: decimal arithmetic on the operands
  function automatic longint unsigned to_dec(
      input logic [63:0] x, input int d);
    longint unsigned v = 0;
    for (int i = d - 1; i >= 0; i--)
      v = v * 10 + longint'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [63:0] to_bcd(
      input longint unsigned v, input int d);
    logic [63:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit is_bcd(
      input logic [63:0] x, input int d);
    for (int i = 0; i < d; i++)
      if (x[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] rand_bcd();
    logic [63:0] r = '0;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  task automatic check_model(input int k,
      input logic [63:0] av, input logic [63:0] bv,
      input logic ci, input logic sb);
    int d;
    longint unsigned m, x, y, t;
    bit ok;
    d = dg[k];
    m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    ok = is_bcd(av, d) && is_bcd(bv, d);
    chk($sformatf("d%0d_err", d), {63'd0, re[k]},
        {63'd0, !ok});
    chk($sformatf("d%0d_lat", d), rl[k], d);
    if (ok) begin
      x = to_dec(av, d);
      y = to_dec(bv, d);
      if (sb) y = m - 1 - y;
      t = x + y + longint'(ci);
      chk($sformatf("d%0d_sum", d), rs[k],
          to_bcd(t % m, d));
      chk($sformatf("d%0d_cout", d), {63'd0, rc[k]},
          {63'd0, t >= m});
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(rdy1 && rdy4 && rdy16) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] av,
      input logic [63:0] bv, input logic ci,
      input logic sb);
    wait_ready();
    a = av; b = bv; cin = ci; sub = sb;
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rg[k] = 1'b0;
      rl[k] = -1;
    end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (!rg[0] && ov1) begin
        rg[0] = 1; rl[0] = cyc;
        rs[0] = {60'd0, s1}; rc[0] = co1; re[0] = er1;
      end
      if (!rg[1] && ov4) begin
        rg[1] = 1; rl[1] = cyc;
        rs[1] = {48'd0, s4}; rc[1] = co4; re[1] = er4;
      end
      if (!rg[2] && ov16) begin
        rg[2] = 1; rl[2] = cyc;
        rs[2] = s16; rc[2] = co16; re[2] = er16;
      end
      if (rg[0] && rg[1] && rg[2]) break;
    end
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        e;
  } vec_t;

  vec_t tv[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cs;
    logic        cc, ce;
    int          n;
    bit          seen;

    dg[0] = 1; dg[1] = 4; dg[2] = 16;
    tv[0] = '{64'h1234, 64'h5678, 0, 0, 16'h6912, 0, 0};
    tv[1] = '{64'h9999, 64'h0001, 0, 0, 16'h0000, 1, 0};
    tv[2] = '{64'h5000, 64'h1234, 1, 1, 16'h3766, 1, 0};
    tv[3] = '{64'h1234, 64'h5000, 1, 1, 16'h6234, 0, 0};
    tv[4] = '{64'h12A4, 64'h0000, 0, 0, 16'h1304, 0, 1};
    tv[5] = '{64'h0007, 64'h0005, 0, 0, 16'h0012, 0, 0};
    tv[6] = '{64'h9999_9999_9999_9999, 64'h1, 0, 0,
              16'h0000, 1, 0};

    // reset state
    tick();
    tick();
    chk("rst_in_ready", {63'd0, rdy4}, 64'd0);
    chk("rst_out_valid", {63'd0, ov4}, 64'd0);
    chk("rst_sum", {48'd0, s4}, 64'd0);
    chk("rst_cout", {63'd0, co4}, 64'd0);
    chk("rst_err", {63'd0, er4}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {63'd0, rdy4}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub);
      chk($sformatf("v%0d_sum", i), rs[1], {48'd0, tv[i].s});
      chk($sformatf("v%0d_cout", i), {63'd0, rc[1]},
          {63'd0, tv[i].c});
      chk($sformatf("v%0d_err", i), {63'd0, re[1]},
          {63'd0, tv[i].e});
      chk($sformatf("v%0d_lat", i), rl[1], 4);
      check_model(0, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub);
      check_model(2, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub);
      if (i == 5) begin
        chk("d1_7p5_sum", rs[0], 64'h2);
        chk("d1_7p5_cout", {63'd0, rc[0]}, 64'd1);
        chk("d1_7p5_lat", rl[0], 1);
      end
      if (i == 6) begin
        chk("d16_all9_sum", rs[2], 64'd0);
        chk("d16_all9_cout", {63'd0, rc[2]}, 64'd1);
        chk("d16_all9_lat", rl[2], 16);
      end
    end

    // backpressure: hold the result in DONE
    wait_ready();
    a = 64'h12A4; b = 64'h0; cin = 0; sub = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin
      tick();
      n++;
    end
    chk("bp_lat", n, 4);
    cs = {48'd0, s4}; cc = co4; ce = er4;
    chk("bp_sum", cs, 64'h1304);
    chk("bp_err", {63'd0, ce}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a = rand_bcd();
      b = rand_bcd();
      tick();
      chk($sformatf("bp%0d_sum", k), {48'd0, s4}, cs);
      chk($sformatf("bp%0d_cout", k), {63'd0, co4},
          {63'd0, cc});
      chk($sformatf("bp%0d_err", k), {63'd0, er4},
          {63'd0, ce});
      chk($sformatf("bp%0d_ov", k), {63'd0, ov4}, 64'd1);
      chk($sformatf("bp%0d_rdy", k), {63'd0, rdy4}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_done_ov", {63'd0, ov4}, 64'd0);
    chk("bp_done_rdy", {63'd0, rdy4}, 64'd1);

    // reset in the middle of RUN
    wait_ready();
    a = 64'h5555; b = 64'h4444; cin = 0; sub = 0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_rdy", {63'd0, rdy4}, 64'd0);
    chk("mid_rst_ov", {63'd0, ov4}, 64'd0);
    chk("mid_rst_sum", {48'd0, s4}, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ov4) seen = 1'b1;
    end
    chk("mid_rst_no_ov", {63'd0, seen}, 64'd0);
    run_op(64'h1, 64'h1, 0, 0);
    chk("post_rst_sum", rs[1], 64'h2);
    chk("post_rst_lat", rl[1], 4);

    // random valid operands on all three widths
    for (int r = 0; r < 40; r++) begin
      logic [63:0] ra, rb;
      logic rci, rsb;
      ra = rand_bcd();
      rb = rand_bcd();
      rci = 1'($urandom_range(1));
      rsb = 1'($urandom_range(1));
      run_op(ra, rb, rci, rsb);
      for (int k = 0; k < 3; k++)
        check_model(k, ra, rb, rci, rsb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised, digit-serial BCD adder/subtractor. Processes one BCD digit per clock, least-significant digit first.
- Replaces fixed-width combinational BCD ripple adders wherever area matters more than latency.
- Adds a subtract mode (ten's complement), invalid-digit detection and valid/ready handshakes on both input and output.

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..16; operand width W = 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and controls are valid this cycle.
- in_ready  output  1  block can accept operands.
- a  input  W  BCD operand A; digit i is in bits [4i+3:4i].
- b  input  W  BCD operand B.
- cin  input  1  carry-in to digit 0.
- sub  input  1  0 = A+B+cin; 1 = A+(9's complement of B)+cin.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  BCD result.
- cout  output  1  carry out of the most significant digit.
- err  output  1  at least one digit of a or b is greater than 9.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; out_valid=0; sum=0; cout=0; err=0.
  - in_ready=0 while rst=1.
  - A reset mid-RUN or in DONE abandons the operation. No out_valid is produced for it.
- in_ready = (state==IDLE) && !rst. It is combinational from state.
- State IDLE:
  - On in_valid && in_ready at an edge: register a, b, cin, sub.
  - Set err = OR over all digits of (digit > 9), across both a and b.
  - Clear digit index to 0 and go to RUN.
  - in_valid while not ready is ignored.
- State RUN, one digit per edge, for digit i:
  - b'_i = sub ? (9 - b_i) mod 16 : b_i.
  - raw = a_i + b'_i + c, with 5-bit arithmetic; c is cin for i=0, otherwise the previous digit's carry.
  - If raw > 9: digit = (raw + 6) mod 16, carry = 1.
  - Otherwise: digit = raw, carry = 0.
  - Write the digit into sum position i (a shift register or indexed write are both acceptable; the result is identical).
- RUN length:
  - After the edge that processes digit DIGITS-1: go to DONE, set out_valid=1, cout = final carry.
  - Latency: out_valid rises exactly DIGITS cycles after the accepting edge.
- State DONE:
  - sum, cout and err are held stable; in_ready=0.
  - On out_ready=1 at an edge: out_valid goes to 0 and state goes to IDLE.
  - in_ready becomes 1 in the following cycle. No same-cycle accept on the completing edge.
- Throughput: at most one operation per DIGITS+2 cycles.
- sum, cout and err are registered. Their values while out_valid=0 are don't-care, except the reset values.
- Subtract semantics: A-B is obtained with sub=1, cin=1.
  - cout=1 means A>=B and sum=A-B.
  - cout=0 means A<B and sum is the ten's complement of B-A.
- Invalid digits:
  - The same arithmetic rule is applied without special-casing.
  - err flags the result as unreliable. err is held with sum until the DONE handshake completes.
- Output handshake: out_ready may be held high permanently. It is ignored outside DONE.
- DIGITS=1:
  - RUN lasts a single cycle.
  - The digit index counter width is max(1, clog2(DIGITS)).

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, cin=0, sub=0 -> sum=0x6912, cout=0, err=0. out_valid rises 4 cycles after the accepting edge.
- a=0x9999, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1. Carry ripples through all four digits.
- Subtract, sub=1, cin=1:
  - a=0x5000, b=0x1234 -> sum=0x3766, cout=1.
  - a=0x1234, b=0x5000 -> sum=0x6234, cout=0.
- Invalid digit: a=0x12A4, b=0x0000, cin=0, sub=0 -> err=1, sum=0x1304, cout=0.
- Backpressure and reset:
  - out_ready held low 5 cycles in DONE -> sum, cout, err stable; out_valid=1; in_ready=0; in_valid pulses are ignored.
  - Then out_ready=1 -> out_valid=0 next cycle, and in_ready=1 the cycle after the handshake edge.
  - rst=1 asserted during RUN (after digit 1) -> next cycle state=IDLE, out_valid=0, sum=0.
  - A fresh operation (0x0001+0x0001) then yields 0x0002 with normal latency.
- Parameter sweep:
  - DIGITS=1: a=0x7, b=0x5 -> sum=0x2, cout=1, latency 1.
  - DIGITS=16: all-9s + 1 -> sum=0, cout=1, latency 16.
